instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
// - Fetch stage of the Jericalla datapath. Walks a PC through a synchronous instruction memory and buffers the returned words.
// - Splits each word into OpCode and register fields and presents them to the Control unit and register file.
// - Uses a valid/ready handshake; a 2-entry buffer absorbs the 1-cycle memory latency under back-pressure.
// PARAMETERS
// - ADDR_W     8        PC / instruction-memory address width
// - INSTR_W    17       instruction width; fixed field map below, must be 17
// - LAST_ADDR  8'hFF    last address fetched; fetching stops after it (compared as an ADDR_W value)
// PORTS
// - clk        in   1        single clock, all state on rising edge
// - rst        in   1        synchronous, active-high reset
// - Start      in   1        pulse: begin fetch at address 0 (honoured in IDLE/DONE only)
// - Stop       in   1        level: stop issuing new reads, drain, go DONE
// - IMemAddr   out  ADDR_W   instruction memory read address (= PC)
// - IMemRe     out  1        read enable; data returns on IMemData next cycle
// - IMemData   in   INSTR_W  read data, valid the cycle after IMemRe
// - InstrValid out  1        buffer head holds a valid instruction
// - InstrReady in   1        consumer accepts head this cycle
// - Instr      out  INSTR_W  raw head word
// - OpCode     out  2        Instr[16:15], feeds Control
// - RA1        out  5        Instr[14:10]
// - RA2        out  5        Instr[9:5]
// - WA         out  5        Instr[4:0]
// - PCOut      out  ADDR_W   address the head word was fetched from
// - Busy       out  1        state is RUN or DRAIN
// - Done       out  1        state is DONE
// BEHAVIOUR
// - FSM states:
//   - IDLE: on Start -> RUN, PC<=0.
//   - RUN: on (Stop | last issued) -> DRAIN.
//   - DRAIN: when inflight==0 and buffer empty -> DONE.
//   - DONE: on Start -> RUN, PC<=0.
// - Start is ignored in RUN and DRAIN.
// - Issue rule, evaluated combinationally in RUN:
//   - IMemRe=1 iff !Stop, !last_issued, and (occupancy + inflight) < 2.
//   - IMemAddr=PC.
//   - On issue: PC<=PC+1; inflight<=1.
//   - Issuing LAST_ADDR sets last_issued.
//   - PC never wraps; the read of LAST_ADDR is the final one, even when LAST_ADDR = 2^ADDR_W-1.
// - Return path:
//   - inflight=1 in cycle c means IMemData is pushed into the buffer at the end of c, tagged with its fetch address.
//   - inflight clears unless a new issue occurs in the same cycle.
// - Buffer:
//   - 2-entry FIFO, in order.
//   - Pop when InstrValid & InstrReady.
//   - Push and pop in the same cycle are both performed; occupancy is unchanged.
//   - Credit rule guarantees a push never occurs when full; no data is ever dropped.
// - Outputs:
//   - Instr, fields and PCOut are driven from the head entry.
//   - They hold stable while InstrValid & !InstrReady.
// - Latency:
//   - IMemRe in cycle c -> InstrValid in cycle c+2 if buffer was empty.
//   - Sustained throughput is 1 instr/cycle with InstrReady held high.
// - Stop in RUN:
//   - Blocks issue in that same cycle.
//   - A read already in flight still completes and is delivered.
//   - Stop is level-sensitive only in RUN.
// - DRAIN: no issue; buffered words continue to be delivered via the handshake.
// - DONE: InstrValid=0; Done=1 until the next Start.
// - Reset values:
//   - State IDLE, PC=0, inflight=0, occupancy=0, last_issued=0.
//   - IMemRe=0, IMemAddr=0, InstrValid=0, Instr/fields/PCOut=0, Busy=0, Done=0.
// - Reset mid-operation discards buffered words and any in-flight response; IMemData the cycle after reset is ignored.
// - Simultaneous events:
//   - rst has priority over everything.
//   - Start and Stop together in IDLE: enter RUN, then Stop moves it to DRAIN next cycle with zero reads issued.
// CONFIGURATION
// - ICOUNT_EN defined:
//   - Adds output FetchCount [15:0], the number of handshakes completed (InstrValid & InstrReady).
//   - Cleared by rst and on each accepted Start.
//   - Saturates at 16'hFFFF.
// - ICOUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
// - Stream: LAST_ADDR=3, mem[i]=17'h0_0421+i, InstrReady=1, Start pulse.
//   - Required: 4 words delivered in order with PCOut 0..3 and first InstrValid 3 cycles after Start.
//   - Then Done=1; IMemRe never addresses 4.
// - Back-pressure: InstrReady=0 for 5 cycles after first InstrValid.
//   - Required: at most 2 reads outstanding and buffered; head stable; IMemRe=0 while full.
//   - On release: no word lost or duplicated.
// - Field split: mem[0]=17'b11_00010_00011_00100.
//   - Required: OpCode=2'b11, RA1=2, RA2=3, WA=4.
// - Stop mid-run: assert Stop the cycle after the IMemRe for addr 5.
//   - Required: words 0..5 delivered, no read of 6, DRAIN -> DONE.
// - Reset mid-run: rst for 1 cycle with 2 words buffered and 1 in flight.
//   - Required: all outputs at reset values next cycle; a later Start delivers from address 0 with no stale word.
// - ICOUNT_EN: run test 1 with the macro defined.
//   - Required: FetchCount=4 at Done; 0 after the next Start.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks a PC through a synchronous instruction memory, buffers
// returned words in a 2-entry FIFO and splits them into fields. ICOUNT_EN adds FetchCount.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                INSTR_W   = 17,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic               Stop,
  output logic [ADDR_W-1:0]  IMemAddr,
  output logic               IMemRe,
  input  logic [INSTR_W-1:0] IMemData,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [1:0]         OpCode,
  output logic [4:0]         RA1,
  output logic [4:0]         RA2,
  output logic [4:0]         WA,
  output logic [ADDR_W-1:0]  PCOut,
  output logic               Busy,
  output logic               Done
`ifdef ICOUNT_EN
  , output logic [15:0]      FetchCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   inflight_addr_q, inflight_addr_d;
  logic                last_issued_q, last_issued_d;
  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [INSTR_W-1:0]  buf_data_q [2];
  logic [ADDR_W-1:0]   buf_addr_q [2];

  logic                start_ok;
  logic                push;
  logic                pop;
  logic                issue;
  logic [1:0]          occ_after_pop;
  logic [1:0]          credit_used;
  logic                head_valid;

  assign head_valid = (count_q != 2'd0);
  assign start_ok   = Start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign push       = inflight_q;
  assign pop        = head_valid && InstrReady;

  // Credit looks at occupancy after this cycle's pop so a streaming consumer
  // sees one word per cycle; buffered + in-flight never exceeds two.
  assign occ_after_pop = count_q - {1'b0, pop};
  assign credit_used   = occ_after_pop + {1'b0, inflight_q};
  assign issue = (state_q == S_RUN) && !Stop && !last_issued_q && (credit_used < 2'd2);

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    last_issued_d   = last_issued_q;
    count_d         = count_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d       = S_RUN;
          pc_d          = '0;
          last_issued_d = 1'b0;
        end
      end
      S_RUN: begin
        if (Stop || last_issued_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (count_q == 2'd0)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      inflight_d      = 1'b1;
      inflight_addr_d = pc_q;
      // The PC parks on the final address instead of wrapping.
      if (pc_q == LAST_ADDR) begin
        last_issued_d = 1'b1;
      end else begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end

    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pc_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      last_issued_q   <= 1'b0;
      count_q         <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      last_issued_q   <= last_issued_d;
      count_q         <= count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_data_q[wr_ptr_q] <= IMemData;
      buf_addr_q[wr_ptr_q] <= inflight_addr_q;
    end
  end

`ifdef ICOUNT_EN
  logic [15:0] fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fetch_cnt_q <= 16'd0;
    end else if (pop && (fetch_cnt_q != 16'hFFFF)) begin
      fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end
  end

  assign FetchCount = fetch_cnt_q;
`endif

  assign IMemRe     = issue;
  assign IMemAddr   = pc_q;
  assign InstrValid = head_valid;
  assign Instr      = head_valid ? buf_data_q[rd_ptr_q] : '0;
  assign PCOut      = head_valid ? buf_addr_q[rd_ptr_q] : '0;
  assign OpCode     = Instr[16:15];
  assign RA1        = Instr[14:10];
  assign RA2        = Instr[9:5];
  assign WA         = Instr[4:0];
  assign Busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign Done       = (state_q == S_DONE);

endmodule
